// File: rtl/exe_trace_buffer.sv
// exe_trace_buffer: execution trace capture buffer.
// Records {PC, IR} of each retired instruction into a circular buffer while
// armed, optionally stops a programmable number of entries after a PC-match
// trigger, then lets software pop the captured entries oldest-first.
//
// Ports:
//   clk, reset_n           core clock, synchronous active-low reset
//   exe_enable, PC_in,     retire strobe and the retired instruction's PC/IR
//   IR_in
//   arm, stop              control pulses: clear and start capture / freeze
//   trigger_en, trigger_pc PC-match trigger enable and address
//   rd_req                 pop the oldest entry (IDLE or FROZEN only)
//   rd_valid, rd_pc, rd_ir popped entry, valid one cycle after rd_req
//   state                  0 IDLE, 1 ARMED, 2 POST_TRIG, 3 FROZEN
//   entry_count            number of valid entries
//   wrapped                sticky: an entry was overwritten since arm
module exe_trace_buffer #(
   parameter int unsigned DEPTH_LOG2 = 6,
   parameter int unsigned POST_TRIG  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  exe_enable,
   input  logic [31:0]           PC_in,
   input  logic [31:0]           IR_in,
   input  logic                  arm,
   input  logic                  stop,
   input  logic                  trigger_en,
   input  logic [31:0]           trigger_pc,
   input  logic                  rd_req,
   output logic                  rd_valid,
   output logic [31:0]           rd_pc,
   output logic [31:0]           rd_ir,
   output logic [1:0]            state,
   output logic [DEPTH_LOG2:0]   entry_count,
   output logic                  wrapped
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned AW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned DW    = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_POST   = 2'd2,
      ST_FROZEN = 2'd3
   } state_t;

   state_t          state_q, state_nxt;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_nxt;
   logic [AW-1:0]   post_q, post_nxt;
   logic [CW-1:0]   count_q, count_nxt;
   logic            wrapped_q, wrapped_nxt;
   logic            rd_valid_nxt;

   logic            capturing_c;
   logic            readable_c;
   logic            capture_c;
   logic            trig_hit_c;
   logic            full_c;
   logic            rd_accept_c;
   logic [AW-1:0]   rd_addr_c;

   logic [DW-1:0]   mem [DEPTH];

   // Capture / read qualification; arm wins over a coincident capture or read
   assign capturing_c = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign readable_c  = (state_q == ST_IDLE) || (state_q == ST_FROZEN);
   assign capture_c   = exe_enable && capturing_c && !arm;
   assign trig_hit_c  = capture_c && (state_q == ST_ARMED) && trigger_en &&
                        (PC_in == trigger_pc);
   assign full_c      = (count_q == CW'(DEPTH));
   assign rd_accept_c = rd_req && readable_c && !arm && (count_q != '0);

   // Oldest entry; when full the low bits of count are 0 so this is wr_ptr
   assign rd_addr_c   = wr_ptr_q - count_q[AW-1:0];

   // Next-state and bookkeeping
   always_comb begin
      state_nxt    = state_q;
      wr_ptr_nxt   = wr_ptr_q;
      post_nxt     = post_q;
      count_nxt    = count_q;
      wrapped_nxt  = wrapped_q;
      rd_valid_nxt = rd_accept_c;

      if (arm) begin
         state_nxt   = ST_ARMED;
         wr_ptr_nxt  = '0;
         post_nxt    = '0;
         count_nxt   = '0;
         wrapped_nxt = 1'b0;
      end else begin
         if (capture_c) begin
            wr_ptr_nxt = wr_ptr_q + AW'(1);
            if (full_c) begin
               wrapped_nxt = 1'b1;
            end else begin
               count_nxt = count_q + CW'(1);
            end
         end

         if (rd_accept_c) begin
            count_nxt = count_q - CW'(1);
         end

         unique case (state_q)
            ST_ARMED: begin
               if (stop) begin
                  state_nxt = ST_FROZEN;
               end else if (trig_hit_c) begin
                  post_nxt = AW'(POST_TRIG);
                  if (POST_TRIG == 0) begin
                     state_nxt = ST_FROZEN;
                  end else begin
                     state_nxt = ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (stop) begin
                  state_nxt = ST_FROZEN;
               end else if (capture_c) begin
                  post_nxt = post_q - AW'(1);
                  if (post_q == AW'(1)) begin
                     state_nxt = ST_FROZEN;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         post_q    <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         wr_ptr_q  <= wr_ptr_nxt;
         post_q    <= post_nxt;
         count_q   <= count_nxt;
         wrapped_q <= wrapped_nxt;
         rd_valid  <= rd_valid_nxt;
      end
   end

   // Trace storage; contents are not reset
   always_ff @(posedge clk) begin
      if (capture_c) begin
         mem[wr_ptr_q] <= {PC_in, IR_in};
      end
   end

   // Read data register, holds its value between pops
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_pc <= '0;
         rd_ir <= '0;
      end else if (rd_accept_c) begin
         {rd_pc, rd_ir} <= mem[rd_addr_c];
      end
   end

   assign state       = state_q;
   assign entry_count = count_q;
   assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_exe_trace_buffer.sv
// tb_exe_trace_buffer: self-checking bench for exe_trace_buffer.
// A queue-based reference model tracks state, contents and flags; popped
// entries are pushed to a scoreboard when rd_req is driven and compared
// when rd_valid appears.
module tb_exe_trace_buffer;

   localparam int unsigned DL2   = 6;
   localparam int unsigned PT    = 16;
   localparam int unsigned DEPTH = 1 << DL2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            exe_enable;
   logic [31:0]     PC_in;
   logic [31:0]     IR_in;
   logic            arm;
   logic            stop;
   logic            trigger_en;
   logic [31:0]     trigger_pc;
   logic            rd_req;
   logic            rd_valid;
   logic [31:0]     rd_pc;
   logic [31:0]     rd_ir;
   logic [1:0]      state;
   logic [DL2:0]    entry_count;
   logic            wrapped;

   exe_trace_buffer #(.DEPTH_LOG2(DL2), .POST_TRIG(PT)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .exe_enable  (exe_enable),
      .PC_in       (PC_in),
      .IR_in       (IR_in),
      .arm         (arm),
      .stop        (stop),
      .trigger_en  (trigger_en),
      .trigger_pc  (trigger_pc),
      .rd_req      (rd_req),
      .rd_valid    (rd_valid),
      .rd_pc       (rd_pc),
      .rd_ir       (rd_ir),
      .state       (state),
      .entry_count (entry_count),
      .wrapped     (wrapped)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] sb[$];
   logic [63:0] mq[$];
   int          ms;
   bit          mw;
   int          mpost;
   logic [63:0] last_rd;
   logic [63:0] mon_exp;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus, with the reference model stepped alongside
   task automatic cyc(input bit en, input logic [31:0] pc, input logic [31:0] ir,
                      input bit a, input bit s, input bit r);
      bit          cap;
      bit          acc;
      logic [63:0] popped;
      popped     = '0;
      exe_enable = en;
      PC_in      = pc;
      IR_in      = ir;
      arm        = a;
      stop       = s;
      rd_req     = r;
      cap = en && (ms == 1 || ms == 2) && !a;
      acc = r && (ms == 0 || ms == 3) && (mq.size() > 0) && !a;
      if (a) begin
         mq.delete();
         mw    = 1'b0;
         ms    = 1;
         mpost = 0;
      end else begin
         if (acc) begin
            popped = mq.pop_front();
            sb.push_back(popped);
         end
         if (cap) begin
            if (mq.size() == DEPTH) begin
               void'(mq.pop_front());
               mw = 1'b1;
            end
            mq.push_back({pc, ir});
         end
         if ((ms == 1 || ms == 2) && s) ms = 3;
         else if (cap && ms == 1 && trigger_en && pc == trigger_pc) begin
            mpost = PT;
            ms    = (PT == 0) ? 3 : 2;
         end else if (cap && ms == 2) begin
            mpost--;
            if (mpost == 0) ms = 3;
         end
      end
      tick();
      chk("state", 64'(state), 64'(ms));
      chk("entry_count", 64'(entry_count), 64'(mq.size()));
      chk("wrapped", 64'(wrapped), 64'(mw));
      chk("rd_valid", 64'(rd_valid), 64'(acc));
      if (acc) last_rd = popped;
      else chk("rd_hold", {rd_pc, rd_ir}, last_rd);
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      exe_enable = 1'b0;
      arm        = 1'b0;
      stop       = 1'b0;
      rd_req     = 1'b0;
      tick();
      reset_n = 1'b1;
      mq.delete();
      ms      = 0;
      mw      = 1'b0;
      mpost   = 0;
      last_rd = '0;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", 64'(entry_count), 64'd0);
      chk("rst_wrapped", 64'(wrapped), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_data", {rd_pc, rd_ir}, 64'd0);
   endtask

   task automatic drain();
      cyc(0, 0, 0, 0, 1, 0);
      while (mq.size() > 0) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   // Scoreboard: compare each popped entry against the expected one
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
         else begin
            mon_exp = sb.pop_front();
            chk("rd_data", {rd_pc, rd_ir}, mon_exp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n    = 1'b0;
      exe_enable = 1'b0;
      PC_in      = '0;
      IR_in      = '0;
      arm        = 1'b0;
      stop       = 1'b0;
      trigger_en = 1'b0;
      trigger_pc = '0;
      rd_req     = 1'b0;
      do_reset();

      // Read with nothing captured in IDLE is ignored
      cyc(0, 0, 0, 0, 0, 1);

      // Five captures, stop, five back-to-back pops
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 32'(i * 4), $urandom, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("five_count", 64'(entry_count), 64'd5);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("five_empty", 64'(entry_count), 64'd0);

      // Wrap: 70 captures into 64 entries, oldest surviving is capture #7
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 70; i++) cyc(1, 32'(i * 4), $urandom, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("wrap_count", 64'(entry_count), 64'(DEPTH));
      chk("wrap_flag", 64'(wrapped), 64'd1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("wrap_first_pc", 64'(rd_pc), 64'd24);
      drain();

      // Reads ignored while ARMED and when empty; capture with stop is kept
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 32'h1000 + 32'(i * 4), $urandom, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 32'h2000, $urandom, 0, 1, 0);
      chk("stop_capture", 64'(entry_count), 64'd4);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);

      // PC trigger with 16 post-trigger entries, no re-trigger
      trigger_en = 1'b1;
      trigger_pc = 32'h100;
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 32'hF0 + 32'(i * 4), $urandom, 0, 0, 0);
      chk("trig_state", 64'(state), 64'd2);
      for (int i = 0; i < 16; i++)
         cyc(1, (i == 3) ? 32'h100 : 32'h104 + 32'(i * 4), $urandom, 0, 0, 0);
      chk("post_frozen", 64'(state), 64'd3);
      chk("post_count", 64'(entry_count), 64'd21);
      for (int i = 0; i < 3; i++) cyc(1, 32'h300, $urandom, 0, 0, 0);
      drain();
      trigger_en = 1'b0;

      // Arm+stop together from FROZEN with 10 entries; coincident capture dropped
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, 32'h500 + 32'(i * 4), $urandom, 0, 0, 0);
      cyc(1, 32'h600, $urandom, 0, 1, 0);
      chk("frz10_count", 64'(entry_count), 64'd10);
      cyc(1, 32'h700, $urandom, 1, 1, 0);
      chk("armstop_state", 64'(state), 64'd1);
      chk("armstop_count", 64'(entry_count), 64'd0);
      chk("armstop_wrapped", 64'(wrapped), 64'd0);

      // Reset while in POST_TRIG with 20 entries
      trigger_en = 1'b1;
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 32'h40 + 32'(i * 4), $urandom, 0, 0, 0);
      cyc(1, 32'h100, $urandom, 0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, 32'h200 + 32'(i * 4), $urandom, 0, 0, 0);
      chk("pre_rst_state", 64'(state), 64'd2);
      chk("pre_rst_count", 64'(entry_count), 64'd20);
      do_reset();

      // Random traffic against the model
      cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 600; i++) begin
         logic [31:0] pc;
         case ($urandom_range(0, 3))
            0:       pc = 32'h100;
            1:       pc = 32'h104;
            default: pc = $urandom;
         endcase
         cyc(1'($urandom_range(0, 1)), pc, $urandom,
             ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 2) == 0));
      end
      drain();
      cyc(0, 0, 0, 0, 0, 0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
